// File: rtl/seq_detect_moore_param_pkg.sv
// Shared types and constants for the parametrised Moore pattern detector.
// Build option: SEQ_MATCH_COUNT_EN adds the saturating match counter.
package seq_det_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_FILL  = 2'd0;
  localparam state_t S_ARMED = 2'd1;
  localparam state_t S_HIT   = 2'd2;

  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 16;

  // Bits needed to hold 0..v-1; called with LEN+1 to size the fill counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_detect_moore_param_if.sv
// Serial bit stream and match outputs of the pattern detector.
// Build option: SEQ_MATCH_COUNT_EN adds match_count and its COUNT_W parameter.
interface seq_detect_moore_param_if
`ifdef SEQ_MATCH_COUNT_EN
  #(parameter int COUNT_W = 8)
`endif
  ;
  logic in;
  logic in_valid;
  logic overlap;
  logic out;
`ifdef SEQ_MATCH_COUNT_EN
  logic [COUNT_W-1:0] match_count;
`endif

  modport master (
    output in, in_valid, overlap,
    input  out
`ifdef SEQ_MATCH_COUNT_EN
    , input match_count
`endif
  );

  modport slave (
    input  in, in_valid, overlap,
    output out
`ifdef SEQ_MATCH_COUNT_EN
    , output match_count
`endif
  );
endinterface

// File: rtl/seq_detect_moore_param_window.sv
// LEN-bit history window with a saturating fill counter.
// Build option: none (SEQ_MATCH_COUNT_EN only affects the top).
module seq_window
  import seq_det_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           shift,
  input  logic           clear,
  input  logic           in,
  output logic [LEN-1:0] window,
  output logic           full
);

  localparam int FILL_W = clog2(LEN + 1);

  logic [FILL_W-1:0] fill;

  // clear wins over a simultaneous shift: the matched bits must not be reused
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shift) begin
      window <= {window[LEN-2:0], in};
      if (fill != FILL_W'(LEN)) fill <= fill + FILL_W'(1);
    end
  end

  // Look-ahead: one more shifted bit leaves the window fully populated.
  assign full = (fill >= FILL_W'(LEN - 1));

endmodule

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial-pattern detector with valid qualifier and overlap mode.
// Build option: SEQ_MATCH_COUNT_EN adds a saturating COUNT_W-bit match counter.
module seq_detect_moore_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1110
`ifdef SEQ_MATCH_COUNT_EN
  , parameter int           COUNT_W = 8
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  seq_detect_moore_param_if.slave  bus
);

  logic [LEN-1:0] window;
  logic           full;
  logic           shift;
  logic           clear;
  logic           match;
  logic           hit;
  logic           unused_msb;
  state_t         state;
  state_t         state_nxt;

  assign shift = bus.in_valid;
  assign match = ({window[LEN-2:0], bus.in} == PATTERN);
  assign hit   = full && match;
  assign clear = shift && hit && !bus.overlap;

  // The oldest bit falls out of the window on the shift that would compare it.
  assign unused_msb = window[LEN-1];

  seq_window #(.LEN(LEN)) u_window (
    .clk    (clk),
    .reset  (reset),
    .shift  (shift),
    .clear  (clear),
    .in     (bus.in),
    .window (window),
    .full   (full)
  );

  // A cleared window after a non-overlapping hit is not full, so S_HIT falls back to S_FILL.
  always_comb begin
    state_nxt = S_FILL;
    if (full) state_nxt = match ? S_HIT : S_ARMED;
  end

  always_ff @(posedge clk) begin
    if (!reset)     state <= S_FILL;
    else if (shift) state <= state_nxt;
  end

  assign bus.out = (state == S_HIT);

`ifdef SEQ_MATCH_COUNT_EN
  logic [COUNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (shift && hit && (count != {COUNT_W{1'b1}}))
      count <= count + COUNT_W'(1);
  end

  assign bus.match_count = count;
`endif

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Three detector configurations share one stimulus stream and are checked against
// a bit-history reference model; directed scenarios plus randomized blocks.
module tb_seq_detect_moore_param;

  logic clk = 1'b0;
  logic reset;
  logic s_in, s_vld, s_ovl;

  always #5 clk = ~clk;

`ifdef SEQ_MATCH_COUNT_EN
  seq_detect_moore_param_if #(.COUNT_W(8)) bus_a ();
  seq_detect_moore_param_if #(.COUNT_W(8)) bus_b ();
  seq_detect_moore_param_if #(.COUNT_W(2)) bus_c ();
  seq_detect_moore_param #(.LEN(4), .PATTERN(4'b1110), .COUNT_W(8))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seq_detect_moore_param #(.LEN(4), .PATTERN(4'b1011), .COUNT_W(8))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  seq_detect_moore_param #(.LEN(2), .PATTERN(2'b11), .COUNT_W(2))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));
`else
  seq_detect_moore_param_if bus_a ();
  seq_detect_moore_param_if bus_b ();
  seq_detect_moore_param_if bus_c ();
  seq_detect_moore_param #(.LEN(4), .PATTERN(4'b1110))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  seq_detect_moore_param #(.LEN(4), .PATTERN(4'b1011))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  seq_detect_moore_param #(.LEN(2), .PATTERN(2'b11))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));
`endif

  assign bus_a.in = s_in;  assign bus_a.in_valid = s_vld;  assign bus_a.overlap = s_ovl;
  assign bus_b.in = s_in;  assign bus_b.in_valid = s_vld;  assign bus_b.overlap = s_ovl;
  assign bus_c.in = s_in;  assign bus_c.in_valid = s_vld;  assign bus_c.overlap = s_ovl;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: bits accepted since the last reset/clear, newest in bit 0.
  int mlen [3] = '{4, 4, 2};
  int mpat [3] = '{4'b1110, 4'b1011, 2'b11};
  int mmax [3] = '{255, 255, 3};
  int hist [3];
  int hlen [3];
  int mout [3];
  int mcnt [3];
  int dhit [3];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hist[k] = 0; hlen[k] = 0; mout[k] = 0; mcnt[k] = 0;
    end
  endtask

  task automatic model_accept(input int k, input bit b, input bit ov);
    int mask;
    bit m;
    mask = (1 << mlen[k]) - 1;
    hist[k] = (hist[k] << 1) | int'(b);
    if (hlen[k] < 32) hlen[k]++;
    m = (hlen[k] >= mlen[k]) && ((hist[k] & mask) == mpat[k]);
    mout[k] = int'(m);
    if (m) begin
      if (mcnt[k] < mmax[k]) mcnt[k]++;
      if (!ov) begin
        hist[k] = 0; hlen[k] = 0;
      end
    end
  endtask

  task automatic check_all(input bit acc);
    chk("out_a", int'(bus_a.out), mout[0]);
    chk("out_b", int'(bus_b.out), mout[1]);
    chk("out_c", int'(bus_c.out), mout[2]);
`ifdef SEQ_MATCH_COUNT_EN
    chk("cnt_a", int'(bus_a.match_count), mcnt[0]);
    chk("cnt_b", int'(bus_b.match_count), mcnt[1]);
    chk("cnt_c", int'(bus_c.match_count), mcnt[2]);
`endif
    if (acc) begin
      dhit[0] += int'(bus_a.out);
      dhit[1] += int'(bus_b.out);
      dhit[2] += int'(bus_c.out);
    end
  endtask

  // Drive at negedge, let the DUT take the posedge, advance the model, check at negedge.
  task automatic step(input bit b, input bit v, input bit ov, input bit rn);
    s_in = b; s_vld = v; s_ovl = ov; reset = rn;
    @(posedge clk);
    if (!rn) model_reset();
    else if (v) for (int k = 0; k < 3; k++) model_accept(k, b, ov);
    @(negedge clk);
    check_all(v && rn);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) dhit[k] = 0;
  endtask

  task automatic send(input logic [15:0] bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ov, 1'b1);
  endtask

  initial begin
    int c6 [8];
    bit ov;
    c6 = '{0, 1, 2, 3, 3, 3, 3, 3};
    s_in = 1'b0; s_vld = 1'b0; s_ovl = 1'b0; reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) dhit[k] = 0;
    @(negedge clk);
    do_reset();
    do_reset();
    chk("rst_out_a", int'(bus_a.out), 0);
`ifdef SEQ_MATCH_COUNT_EN
    chk("rst_cnt_a", int'(bus_a.match_count), 0);
`endif

    // 1: default pattern, non-overlapping
    send(16'b1110_1111_0111_011, 15, 1'b0);
    chk("t1_hits_a", dhit[0], 3);
`ifdef SEQ_MATCH_COUNT_EN
    chk("t1_cnt_a", int'(bus_a.match_count), 3);
`endif

    // 2/3: 1011 with and without overlap
    do_reset();
    send(16'b1011011, 7, 1'b1);
    chk("t2_hits_b", dhit[1], 2);
`ifdef SEQ_MATCH_COUNT_EN
    chk("t2_cnt_b", int'(bus_b.match_count), 2);
`endif
    do_reset();
    send(16'b1011011, 7, 1'b0);
    chk("t3_hits_b", dhit[1], 1);
`ifdef SEQ_MATCH_COUNT_EN
    chk("t3_cnt_b", int'(bus_b.match_count), 1);
`endif

    // 4: gaps in the stream, out holds through invalid cycles
    do_reset();
    send(16'b11, 2, 1'b0);
    for (int i = 0; i < 5; i++) step(i[0], 1'b0, 1'b0, 1'b1);
    send(16'b10, 2, 1'b0);
    for (int i = 0; i < 4; i++) step(i[0], 1'b0, 1'b0, 1'b1);
    chk("t4_hold_a", int'(bus_a.out), 1);
    chk("t4_hits_a", dhit[0], 1);

    // 5: reset mid-pattern discards the partial match
    do_reset();
    send(16'b111, 3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_rst_out_a", int'(bus_a.out), 0);
    send(16'b0, 1, 1'b0);
    chk("t5_nohit_a", dhit[0], 0);
    send(16'b1110, 4, 1'b0);
    chk("t5_hit_a", dhit[0], 1);

    // 6: LEN=2 overlapping, counter saturation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("t6_out_c", int'(bus_c.out), (i >= 1) ? 1 : 0);
`ifdef SEQ_MATCH_COUNT_EN
      chk("t6_cnt_c", int'(bus_c.match_count), c6[i]);
`endif
    end

    // Randomized blocks, overlap fixed per block
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      ov = 1'($urandom_range(0, 1));
      for (int i = 0; i < 500; i++)
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ov,
             ($urandom_range(0, 63) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
